// File: rtl/oam_dma_engine_if.sv
// Bus bundle between the OAM DMA engine and the CPU snoop, source bus, OAM and MMU.
// master = the engine side, slave = the system side.
interface oam_dma_engine_if;
  logic [15:0] A_cpu;
  logic [7:0]  Di_cpu;
  logic        wr_cpu;
  logic [7:0]  DMA;
  logic [15:0] A_src;
  logic        rd_src;
  logic [7:0]  Di_src;
  logic [7:0]  A_oam;
  logic [7:0]  Do_oam;
  logic        wr_oam;
  logic        dma_active;

  modport master (
    input  A_cpu, Di_cpu, wr_cpu, Di_src,
    output DMA, A_src, rd_src, A_oam, Do_oam, wr_oam, dma_active
  );

  modport slave (
    output A_cpu, Di_cpu, wr_cpu, Di_src,
    input  DMA, A_src, rd_src, A_oam, Do_oam, wr_oam, dma_active
  );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies 160 bytes from page src into OAM at one byte per 4 cycles.
// Define OAM_DMA_RESTART_EN to let a 0xFF46 write during a transfer restart it.
module oam_dma_engine (
  input logic              clk,
  input logic              reset,
  oam_dma_engine_if.master bus
);

  localparam logic [1:0]  StIdle     = 2'd0;
  localparam logic [1:0]  StStart    = 2'd1;
  localparam logic [1:0]  StXfer     = 2'd2;
  localparam logic [15:0] DmaRegAddr = 16'hFF46;
  localparam logic [7:0]  LastIdx    = 8'd159;
  localparam logic [7:0]  EchoBase   = 8'hE0;

  logic [1:0] state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] dma_q, dma_d;

  logic       reg_wr;
  logic       in_xfer;
  logic       rd_phase;
  logic       wr_phase;
  logic [7:0] src;

  assign reg_wr   = bus.wr_cpu && (bus.A_cpu == DmaRegAddr);
  // Pages 0xE0-0xFF alias work RAM 0x20 pages lower (echo RAM).
  assign src      = (dma_q >= EchoBase) ? (dma_q - 8'h20) : dma_q;
  assign in_xfer  = (state_q == StXfer);
  assign rd_phase = in_xfer && (phase_q == 2'd0);
  assign wr_phase = in_xfer && (phase_q == 2'd2);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    dma_d   = dma_q;
    case (state_q)
      StIdle: begin
        if (reg_wr) begin
          dma_d   = bus.Di_cpu;
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StXfer;
        phase_d = 2'd0;
        idx_d   = 8'd0;
      end
      StXfer: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          latch_d = bus.Di_src;
        end
        if (phase_q == 2'd3) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = 8'd0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = 2'd0;
        idx_d   = 8'd0;
      end
    endcase
`ifdef OAM_DMA_RESTART_EN
    // A register write mid-transfer starts over from byte 0 of the new page.
    if ((state_q != StIdle) && reg_wr) begin
      dma_d   = bus.Di_cpu;
      state_d = StStart;
      phase_d = 2'd0;
      idx_d   = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= 2'd0;
      idx_q   <= 8'd0;
      latch_q <= 8'h00;
      dma_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      dma_q   <= dma_d;
    end
  end

  // Address and data buses are held at zero whenever their strobe is idle.
  always_comb begin
    bus.rd_src     = rd_phase;
    bus.A_src      = rd_phase ? {src, idx_q} : 16'h0000;
    bus.wr_oam     = wr_phase;
    bus.A_oam      = wr_phase ? idx_q : 8'h00;
    bus.Do_oam     = wr_phase ? latch_q : 8'h00;
    bus.dma_active = (state_q != StIdle);
    bus.DMA        = dma_q;
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Self-checking bench for oam_dma_engine: table vectors, full-transfer timing model,
// randomized pages/bus noise, mid-transfer reset and restart behaviour.
module tb_oam_dma_engine;

  logic clk;
  logic reset;
  oam_dma_engine_if bus ();

  oam_dma_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_bad;
  int unsigned wr_cnt;
  logic [7:0]  key;

  // Source memory contents: byte at address a.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ key;
  endfunction

  // Source bus returns data one cycle after the read strobe; noise otherwise.
  always @(posedge clk) begin
    if (bus.rd_src) bus.Di_src <= src_byte(bus.A_src);
    else            bus.Di_src <= 8'($urandom);
  end

  // Observable bundle: {dma_active, rd_src, A_src, wr_oam, A_oam, Do_oam, DMA}
  function automatic logic [42:0] observed();
    return {bus.dma_active, bus.rd_src, bus.A_src, bus.wr_oam, bus.A_oam, bus.Do_oam,
            bus.DMA};
  endfunction

  function automatic logic [42:0] idle_bundle(input logic [7:0] dv);
    return {1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, dv};
  endfunction

  // Expected bundle k cycles after the start edge of a transfer of page dv.
  function automatic logic [42:0] expect_at(input logic [7:0] dv, input int k);
    logic [7:0]  sp;
    logic        act, rd, wr;
    logic [15:0] asrc;
    logic [7:0]  aoam, doam;
    sp   = (dv >= 8'hE0) ? dv - 8'h20 : dv;
    act  = (k >= 1) && (k <= 641);
    rd   = act && (k >= 2) && ((k - 2) % 4 == 0);
    wr   = act && (k >= 4) && ((k - 4) % 4 == 0);
    asrc = rd ? {sp, 8'((k - 2) / 4)} : 16'h0000;
    aoam = wr ? 8'((k - 4) / 4) : 8'h00;
    doam = wr ? src_byte({sp, aoam}) : 8'h00;
    return {act, rd, asrc, wr, aoam, doam, dv};
  endfunction

  function automatic string show(input logic [42:0] b);
    return $sformatf("act=%b rd=%b A_src=%h wr=%b A_oam=%h Do_oam=%h DMA=%h",
                     b[42], b[41], b[40:25], b[24], b[23:16], b[15:8], b[7:0]);
  endfunction

  task automatic check(input string name, input logic [42:0] want);
    logic [42:0] got;
    got = observed();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got {%s} want {%s}", name, show(got), show(want));
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic bus_idle();
    bus.wr_cpu = 1'b0;
    bus.A_cpu  = 16'h0000;
    bus.Di_cpu = 8'h00;
  endtask

  // Present a CPU write for exactly one rising edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.wr_cpu = 1'b1;
    bus.A_cpu  = a;
    bus.Di_cpu = d;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  // Check cycles k_first..k_last of a transfer of page dv (sampled on falling edges).
  task automatic run_xfer(input logic [7:0] dv, input int k_first, input int k_last,
                          input bit noise, input string tag);
    logic [15:0] a;
    for (int k = k_first; k <= k_last; k++) begin
      @(negedge clk);
      if (bus.wr_oam) wr_cnt++;
      check($sformatf("%s k=%0d", tag, k), expect_at(dv, k));
      if (noise && k != k_last) begin
        a = 16'($urandom);
        if (a == 16'hFF46) a = 16'hFF47;
        bus.A_cpu  = a;
        bus.Di_cpu = 8'($urandom);
        bus.wr_cpu = 1'($urandom);
      end else begin
        bus_idle();
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_dma;
    logic        exp_act;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] v;
    logic [7:0] w;
    n_vec  = 0;
    n_bad  = 0;
    wr_cnt = 0;
    key    = 8'h00;
    reset  = 1'b1;
    bus_idle();

    tbl[0] = '{wr: 1'b1, a: 16'hFF47, d: 8'h12, exp_dma: 8'hFF, exp_act: 1'b0};
    tbl[1] = '{wr: 1'b0, a: 16'hFF46, d: 8'h34, exp_dma: 8'hFF, exp_act: 1'b0};
    tbl[2] = '{wr: 1'b1, a: 16'hFF45, d: 8'h56, exp_dma: 8'hFF, exp_act: 1'b0};
    tbl[3] = '{wr: 1'b1, a: 16'h7F46, d: 8'h78, exp_dma: 8'hFF, exp_act: 1'b0};
    tbl[4] = '{wr: 1'b1, a: 16'hFE46, d: 8'h9A, exp_dma: 8'hFF, exp_act: 1'b0};
    tbl[5] = '{wr: 1'b1, a: 16'hFF46, d: 8'hC1, exp_dma: 8'hC1, exp_act: 1'b1};

    repeat (3) @(negedge clk);
    check("reset_state", idle_bundle(8'hFF));
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", idle_bundle(8'hFF));

    // Register snoop vectors; the final entry launches the 0xC1 transfer.
    for (int i = 0; i < 6; i++) begin
      bus.wr_cpu = tbl[i].wr;
      bus.A_cpu  = tbl[i].a;
      bus.Di_cpu = tbl[i].d;
      @(posedge clk);
      #1;
      bus_idle();
      @(negedge clk);
      check($sformatf("table[%0d]", i),
            {tbl[i].exp_act, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, tbl[i].exp_dma});
    end
    wr_cnt = 0;
    run_xfer(8'hC1, 2, 645, 1'b0, "xfer_C1");
    check_int("xfer_C1 oam writes", int'(wr_cnt), 160);

    // Echo-RAM page: 0xFE reads from 0xDE00..0xDE9F.
    cpu_write(16'hFF46, 8'hFE);
    run_xfer(8'hFE, 1, 643, 1'b0, "xfer_FE");

    // Random pages and data with unrelated CPU bus traffic during the transfer.
    for (int r = 0; r < 3; r++) begin
      v   = 8'($urandom);
      key = 8'($urandom);
      wr_cnt = 0;
      cpu_write(16'hFF46, v);
      run_xfer(v, 1, 644, 1'b1, $sformatf("rand%0d_%h", r, v));
      check_int($sformatf("rand%0d oam writes", r), int'(wr_cnt), 160);
    end
    key = 8'h00;

    // Reset in cycle 200 with a simultaneous 0xFF46 write: reset wins.
    cpu_write(16'hFF46, 8'hC3);
    run_xfer(8'hC3, 1, 200, 1'b0, "pre_reset");
    reset      = 1'b1;
    bus.wr_cpu = 1'b1;
    bus.A_cpu  = 16'hFF46;
    bus.Di_cpu = 8'h55;
    for (int k = 201; k <= 203; k++) begin
      @(negedge clk);
      check($sformatf("in_reset k=%0d", k), idle_bundle(8'hFF));
    end
    reset = 1'b0;
    bus_idle();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("after_reset k=%0d", k), idle_bundle(8'hFF));
    end

    // Second 0xFF46 write in cycle 100 of a 0xC0 transfer.
    cpu_write(16'hFF46, 8'hC0);
    run_xfer(8'hC0, 1, 100, 1'b0, "restart_a");
    cpu_write(16'hFF46, 8'hD0);
`ifdef OAM_DMA_RESTART_EN
    run_xfer(8'hD0, 1, 643, 1'b0, "restart_b");
`else
    run_xfer(8'hC0, 101, 643, 1'b0, "restart_b");
`endif

    // Write landing on the final phase-3 edge.
    v = 8'h8A;
    w = 8'h21;
    cpu_write(16'hFF46, v);
    run_xfer(v, 1, 641, 1'b0, "last_a");
    cpu_write(16'hFF46, w);
`ifdef OAM_DMA_RESTART_EN
    run_xfer(w, 1, 643, 1'b0, "last_b");
`else
    run_xfer(v, 642, 646, 1'b0, "last_b");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
